multisim_apb_fsm_block: RTL and testbench

MULTISIM_APB_FSM_BLOCK -- requirements
Module: multisim_apb_fsm

---
 rtl/multisim_apb_pkg.sv | 20 ++
 rtl/multisim_apb_fsm_block.sv | 96 +++++++++
 tb/tb_multisim_apb_fsm_block.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/multisim_apb_pkg.sv
// Shared types and decode helpers for the APB manager phase FSM.
package multisim_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } multisim_apb_state_t;

    localparam logic [1:0] STATE_ILLEGAL = 2'd3;

    function automatic logic state_is_active(input multisim_apb_state_t s);
        return s != IDLE;
    endfunction

    function automatic logic state_is_access(input multisim_apb_state_t s);
        return s == ACCESS;
    endfunction

endpackage

// File: rtl/multisim_apb_fsm_block.sv
// APB manager phase sequencer (IDLE/SETUP/ACCESS) with wait-state counter and sticky timeout.
// Latency: request seen in IDLE -> SETUP -> ACCESS; completion reported combinationally in ACCESS.
// Backpressure: ACCESS is held for as long as pready stays low; psel drop never aborts a transfer.
import multisim_apb_pkg::*;

module multisim_apb_fsm_block #(
    parameter int          WAIT_CNT_W     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_apb_psel,
    input  logic                  i_apb_pready,
    output multisim_apb_state_t   state,
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_xfer_done,
    output logic [WAIT_CNT_W-1:0] o_wait_cnt,
    output logic                  o_timeout
);

    localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);
    // Compare in a width that holds both the counter and the threshold.
    localparam int CMP_W = (WAIT_CNT_W > 32) ? WAIT_CNT_W : 32;
    localparam logic [CMP_W-1:0] TIMEOUT_CMP = CMP_W'(TIMEOUT_CYCLES);

    multisim_apb_state_t   state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;

    always_comb begin
        state_d    = IDLE;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;

        case (state_q)
            IDLE: begin
                state_d = i_apb_psel ? SETUP : IDLE;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!i_apb_pready) begin
                    state_d = ACCESS;
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = i_apb_psel ? SETUP : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // SETUP is only reachable from IDLE or ACCESS, so this is always an entry.
        if (state_d == SETUP) begin
            wait_cnt_d = '0;
            timeout_d  = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && (CMP_W'(wait_cnt_d) == TIMEOUT_CMP)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign state       = state_q;
    assign o_psel      = state_is_active(state_q);
    assign o_penable   = state_is_access(state_q);
    assign o_xfer_done = state_is_access(state_q) && i_apb_pready;
    assign o_wait_cnt  = wait_cnt_q;
    assign o_timeout   = timeout_q;

    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        2'(state_q) != STATE_ILLEGAL);

    a_setup_then_access: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SETUP) |=> (state_q == ACCESS));

    a_penable_has_psel: assert property (@(posedge clk) disable iff (!rst_n)
        o_penable |-> o_psel);

endmodule

// File: tb/tb_multisim_apb_fsm_block.sv
// Directed bench for multisim_apb_fsm_block: three parameterisations share one stimulus stream,
// a transfer-level model is checked every cycle, and literal expectations pin key scenarios.
import multisim_apb_pkg::*;

module tb_multisim_apb_fsm_block;

    logic clk = 1'b0;
    logic rst_n;
    logic psel;
    logic pready;

    // A: WAIT_CNT_W=16, TIMEOUT_CYCLES=4
    multisim_apb_state_t st_a;
    logic ps_a, pe_a, xd_a, to_a;
    logic [15:0] cnt_a;
    // B: WAIT_CNT_W=2, TIMEOUT_CYCLES=0
    multisim_apb_state_t st_b;
    logic ps_b, pe_b, xd_b, to_b;
    logic [1:0] cnt_b;
    // C: defaults (16, 1024)
    multisim_apb_state_t st_c;
    logic ps_c, pe_c, xd_c, to_c;
    logic [15:0] cnt_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multisim_apb_fsm_block #(.WAIT_CNT_W(16), .TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_apb_psel(psel), .i_apb_pready(pready),
        .state(st_a), .o_psel(ps_a), .o_penable(pe_a), .o_xfer_done(xd_a),
        .o_wait_cnt(cnt_a), .o_timeout(to_a));

    multisim_apb_fsm_block #(.WAIT_CNT_W(2), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_apb_psel(psel), .i_apb_pready(pready),
        .state(st_b), .o_psel(ps_b), .o_penable(pe_b), .o_xfer_done(xd_b),
        .o_wait_cnt(cnt_b), .o_timeout(to_b));

    multisim_apb_fsm_block dut_c (
        .clk(clk), .rst_n(rst_n), .i_apb_psel(psel), .i_apb_pready(pready),
        .state(st_c), .o_psel(ps_c), .o_penable(pe_c), .o_xfer_done(xd_c),
        .o_wait_cnt(cnt_c), .o_timeout(to_c));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: is a transfer open, how long has it been open, how many waits so far.
    bit m_busy  = 1'b0;
    int m_age   = 0;
    int m_waits = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_age   = 0;
            m_waits = 0;
        end else if (!m_busy) begin
            if (psel) begin
                m_busy  = 1'b1;
                m_age   = 0;
                m_waits = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (!pready) begin
            m_waits++;
        end else if (psel) begin
            m_age   = 0;
            m_waits = 0;
        end else begin
            m_busy = 1'b0;
        end
    end

    function automatic int exp_state();
        if (!m_busy) return 0;
        return (m_age == 0) ? 1 : 2;
    endfunction

    function automatic int exp_cnt(input int w);
        int mx;
        mx = (1 << w) - 1;
        return (m_waits > mx) ? mx : m_waits;
    endfunction

    function automatic bit exp_to(input int w, input int tmo);
        return (tmo > 0) && (exp_cnt(w) >= tmo);
    endfunction

    task automatic check_inst(input string tag, input logic [1:0] st, input logic ps,
                              input logic pe, input logic xd, input logic [15:0] cnt,
                              input logic tmo_flag, input int w, input int tmo);
        int es;
        es = exp_state();
        chk({tag, "_state"}, st, es);
        chk({tag, "_psel"}, ps, es != 0);
        chk({tag, "_penable"}, pe, es == 2);
        chk({tag, "_xfer_done"}, xd, (es == 2) && (pready === 1'b1));
        chk({tag, "_wait_cnt"}, cnt, exp_cnt(w));
        chk({tag, "_timeout"}, tmo_flag, exp_to(w, tmo));
    endtask

    always @(negedge clk) begin
        check_inst("a", st_a, ps_a, pe_a, xd_a, cnt_a, to_a, 16, 4);
        check_inst("b", st_b, ps_b, pe_b, xd_b, {14'd0, cnt_b}, to_b, 2, 0);
        check_inst("c", st_c, ps_c, pe_c, xd_c, cnt_c, to_c, 16, 1024);
    end

    task automatic step(input logic ps, input logic pr);
        psel   = ps;
        pready = pr;
        @(posedge clk);
        #2;
    endtask

    logic [1:0] vec [0:15];
    int xfer_count;

    initial begin
        rst_n  = 1'b0;
        psel   = 1'b0;
        pready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", st_a, 0);
        chk("reset_psel", ps_a, 0);
        chk("reset_wait_cnt", cnt_a, 0);
        chk("reset_timeout", to_a, 0);
        rst_n = 1'b1;

        // Continuous back-to-back transfers alternate SETUP/ACCESS.
        xfer_count = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1);
            chk("b2b_state", st_c, (k % 2 == 1) ? 1 : 2);
            if (xd_c) xfer_count++;
        end
        chk("b2b_done_count", xfer_count, 4);
        step(1'b0, 1'b1);
        chk("b2b_end_idle", st_c, 0);

        // Single transfer with three wait states.
        step(1'b1, 1'b0);
        chk("wait3_setup", st_a, 1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        pready = 1'b1;
        #1;
        chk("wait3_state", st_a, 2);
        chk("wait3_done", xd_a, 1);
        chk("wait3_cnt", cnt_a, 3);
        step(1'b0, 1'b1);
        chk("wait3_idle", st_a, 0);

        // psel dropped during SETUP still completes.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("drop_access", st_a, 2);
        chk("drop_done", xd_a, 1);
        step(1'b0, 1'b1);
        chk("drop_idle", st_a, 0);

        // Timeout at four waits (A) and saturation at three (B).
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0);
            chk("to_state", st_a, 2);
            chk("to_flag_a", to_a, (k >= 4) ? 1 : 0);
            chk("sat_cnt_b", cnt_b, (k < 3) ? k : 3);
            chk("sat_to_b", to_b, 0);
            chk("cnt_c", cnt_c, k);
        end
        step(1'b1, 1'b1);
        chk("to_clear_state", st_a, 1);
        chk("to_clear_flag", to_a, 0);
        chk("to_clear_cnt", cnt_a, 0);

        // Asynchronous reset mid-ACCESS.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("pre_rst_cnt", cnt_a, 2);
        #1 rst_n = 1'b0;
        pready = 1'b1;
        #1;
        chk("arst_state", st_a, 0);
        chk("arst_psel", ps_a, 0);
        chk("arst_penable", pe_a, 0);
        chk("arst_done", xd_a, 0);
        chk("arst_cnt", cnt_a, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b1);
        chk("post_rst_setup", st_a, 1);

        // Mixed directed vectors {psel, pready}, model-checked every cycle.
        vec = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11,
                2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 16; i++) step(vec[i][1], vec[i][0]);

        step(1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
